// File: rtl/turfio_trig_merge.sv
// Trigger merger for one TURFIO port: per-SURF 2-entry FIFOs feeding a round-robin
// arbiter onto a single valid/ready stream tagged with the SURF index.
module turfio_trig_merge #(
  parameter int NUM_SURF  = 8,
  parameter int WORD_BITS = 16,
  parameter int CNT_BITS  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_SURF*WORD_BITS-1:0] trig_i,
  input  logic [NUM_SURF-1:0]           trig_valid_i,
  input  logic [NUM_SURF-1:0]           enable_i,
  output logic [WORD_BITS-1:0]          m_tdata_o,
  output logic [$clog2(NUM_SURF)-1:0]   m_tuser_o,
  output logic                          m_tvalid_o,
  input  logic                          m_tready_i,
  output logic [NUM_SURF-1:0]           overflow_o,
  output logic [CNT_BITS-1:0]           ovf_count_o,
  input  logic                          ovf_clear_i
);

  localparam int IDX_BITS = $clog2(NUM_SURF);
  localparam int POP_BITS = $clog2(NUM_SURF + 1);

  logic [NUM_SURF-1:0]                push_req;
  logic [NUM_SURF-1:0]                push_ok;
  logic [NUM_SURF-1:0]                full;
  logic [NUM_SURF-1:0]                nonempty;
  logic [NUM_SURF-1:0]                drop;
  logic [NUM_SURF-1:0]                pop;
  logic [NUM_SURF-1:0][WORD_BITS-1:0] head_word;

  logic                 load;
  logic                 grant_valid;
  logic [IDX_BITS-1:0]  grant_idx;
  logic [IDX_BITS-1:0]  ptr_reg;
  logic [IDX_BITS-1:0]  ptr_next;

  logic [WORD_BITS-1:0] tdata_reg;
  logic [IDX_BITS-1:0]  tuser_reg;
  logic                 tvalid_reg;
  logic [NUM_SURF-1:0]  overflow_reg;
  logic [NUM_SURF-1:0]  overflow_next;
  logic [CNT_BITS-1:0]  count_reg;
  logic [CNT_BITS-1:0]  count_next;
  logic [CNT_BITS-1:0]  count_base;
  logic [CNT_BITS:0]    count_sum;
  logic [POP_BITS-1:0]  drop_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SURF; gi++) begin : g_lane
      logic [WORD_BITS-1:0] mem_reg [2];
      logic                 wr_ptr_reg;
      logic                 rd_ptr_reg;
      logic [1:0]           fill_reg;

      assign push_req[gi]  = trig_valid_i[gi] & enable_i[gi];
      assign full[gi]      = (fill_reg == 2'd2);
      assign nonempty[gi]  = (fill_reg != 2'd0);
      // A full lane still accepts a word when its head is leaving this cycle.
      assign push_ok[gi]   = push_req[gi] & (~full[gi] | pop[gi]);
      assign drop[gi]      = push_req[gi] & full[gi] & ~pop[gi];
      assign head_word[gi] = mem_reg[rd_ptr_reg];

      always_ff @(posedge clk_i) begin
        if (push_ok[gi]) begin
          mem_reg[wr_ptr_reg] <= trig_i[WORD_BITS*gi +: WORD_BITS];
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          wr_ptr_reg <= 1'b0;
          rd_ptr_reg <= 1'b0;
          fill_reg   <= 2'd0;
        end else begin
          if (push_ok[gi]) wr_ptr_reg <= ~wr_ptr_reg;
          if (pop[gi])     rd_ptr_reg <= ~rd_ptr_reg;
          case ({push_ok[gi], pop[gi]})
            2'b10:   fill_reg <= fill_reg + 2'd1;
            2'b01:   fill_reg <= fill_reg - 2'd1;
            default: fill_reg <= fill_reg;
          endcase
        end
      end
    end
  endgenerate

  assign load = ~tvalid_reg | m_tready_i;

  // Scan from the far end so the lane closest to the pointer wins last.
  always_comb begin
    logic [IDX_BITS-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_SURF - 1; k >= 0; k--) begin
      cand = IDX_BITS'((int'(ptr_reg) + k) % NUM_SURF);
      if (nonempty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    pop      = '0;
    ptr_next = IDX_BITS'((int'(grant_idx) + 1) % NUM_SURF);
    if (load && grant_valid) pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tdata_reg  <= '0;
      tuser_reg  <= '0;
      tvalid_reg <= 1'b0;
      ptr_reg    <= '0;
    end else if (load) begin
      if (grant_valid) begin
        tdata_reg  <= head_word[grant_idx];
        tuser_reg  <= grant_idx;
        tvalid_reg <= 1'b1;
        ptr_reg    <= ptr_next;
      end else begin
        tvalid_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int j = 0; j < NUM_SURF; j++) begin
      drop_cnt = drop_cnt + POP_BITS'(drop[j]);
    end
  end

  // A clear and drops in the same cycle: clear first, then apply the drops.
  always_comb begin
    count_base    = ovf_clear_i ? '0 : count_reg;
    count_sum     = {1'b0, count_base} + (CNT_BITS + 1)'(drop_cnt);
    count_next    = count_sum[CNT_BITS] ? '1 : count_sum[CNT_BITS-1:0];
    overflow_next = (ovf_clear_i ? '0 : overflow_reg) | drop;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_reg <= '0;
      count_reg    <= '0;
    end else begin
      overflow_reg <= overflow_next;
      count_reg    <= count_next;
    end
  end

  assign m_tdata_o   = tdata_reg;
  assign m_tuser_o   = tuser_reg;
  assign m_tvalid_o  = tvalid_reg;
  assign overflow_o  = overflow_reg;
  assign ovf_count_o = count_reg;

endmodule

// File: tb/tb_turfio_trig_merge.sv
// Directed bench for turfio_trig_merge: one task per scenario, inline checks,
// expected values worked out by hand from the intended behaviour.
module tb_turfio_trig_merge;

  logic         clk;
  logic         rst;
  logic [127:0] trig;
  logic [7:0]   trig_valid;
  logic [7:0]   enable;
  logic [15:0]  m_tdata;
  logic [2:0]   m_tuser;
  logic         m_tvalid;
  logic         m_tready;
  logic [7:0]   overflow;
  logic [15:0]  ovf_count;
  logic         ovf_clear;

  int n_checks = 0;
  int n_fail   = 0;

  turfio_trig_merge #(.NUM_SURF(8), .WORD_BITS(16), .CNT_BITS(16)) dut (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .trig_valid_i(trig_valid),
    .enable_i(enable), .m_tdata_o(m_tdata), .m_tuser_o(m_tuser),
    .m_tvalid_o(m_tvalid), .m_tready_i(m_tready), .overflow_o(overflow),
    .ovf_count_o(ovf_count), .ovf_clear_i(ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; outputs are read 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; trig = '0; trig_valid = '0; enable = 8'hFF;
    m_tready = 1'b1; ovf_clear = 1'b0;
    step(); step();
    rst = 1'b0;
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %h expected 0", m_tvalid); end
    n_checks++; if (m_tdata !== 16'h0) begin n_fail++; $display("FAIL reset_tdata got %h expected 0000", m_tdata); end
    n_checks++; if (m_tuser !== 3'd0) begin n_fail++; $display("FAIL reset_tuser got %0d expected 0", m_tuser); end
    n_checks++; if (overflow !== 8'h00) begin n_fail++; $display("FAIL reset_overflow got %h expected 00", overflow); end
    n_checks++; if (ovf_count !== 16'h0) begin n_fail++; $display("FAIL reset_count got %h expected 0000", ovf_count); end
  endtask

  task automatic test_single_word();
    trig[2*16 +: 16] = 16'hBEEF; trig_valid = 8'h04;
    step();
    trig_valid = 8'h00;
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_latency_n1 got %h expected 0", m_tvalid); end
    step();
    $display("single: tvalid=%0d tuser=%0d tdata=%h", m_tvalid, m_tuser, m_tdata);
    n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_tvalid got %h expected 1", m_tvalid); end
    n_checks++; if (m_tdata !== 16'hBEEF) begin n_fail++; $display("FAIL single_tdata got %h expected beef", m_tdata); end
    n_checks++; if (m_tuser !== 3'd2) begin n_fail++; $display("FAIL single_tuser got %0d expected 2", m_tuser); end
    n_checks++; if (overflow !== 8'h00) begin n_fail++; $display("FAIL single_overflow got %h expected 00", overflow); end
    step();
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_idle got %h expected 0", m_tvalid); end
    // Pointer is now 3: lanes 0 and 3 together must come out 3 then 0.
    trig[0 +: 16] = 16'hA000; trig[3*16 +: 16] = 16'hA003; trig_valid = 8'h09;
    step();
    trig_valid = 8'h00;
    step();
    n_checks++; if (m_tuser !== 3'd3 || m_tdata !== 16'hA003) begin n_fail++; $display("FAIL ptr3_first got %0d/%h expected 3/a003", m_tuser, m_tdata); end
    step();
    n_checks++; if (m_tuser !== 3'd0 || m_tdata !== 16'hA000) begin n_fail++; $display("FAIL ptr3_second got %0d/%h expected 0/a000", m_tuser, m_tdata); end
    step();
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL ptr3_idle got %h expected 0", m_tvalid); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_lane;
    // Lane 7 brings the pointer back to 0.
    trig[7*16 +: 16] = 16'h7777; trig_valid = 8'h80;
    step(); trig_valid = 8'h00; step();
    n_checks++; if (m_tuser !== 3'd7 || m_tvalid !== 1'b1) begin n_fail++; $display("FAIL rr_lane7 got %0d/%h expected 7/1", m_tuser, m_tvalid); end
    step();
    for (int j = 0; j < 8; j++) trig[j*16 +: 16] = 16'h1000 + 16'(j);
    trig_valid = 8'hFF;
    step(); trig_valid = 8'h00;
    for (int k = 0; k < 8; k++) begin
      step();
      exp_lane = 3'(k);
      $display("rr_p0: tvalid=%0d tuser=%0d tdata=%h", m_tvalid, m_tuser, m_tdata);
      n_checks++; if (m_tvalid !== 1'b1 || m_tuser !== exp_lane || m_tdata !== (16'h1000 + 16'(k)))
        begin n_fail++; $display("FAIL rr_p0_word%0d got %0d/%0d/%h expected 1/%0d/%h", k, m_tvalid, m_tuser, m_tdata, exp_lane, 16'h1000 + 16'(k)); end
    end
    step();
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rr_p0_idle got %h expected 0", m_tvalid); end
    // Lane 4 moves the pointer to 5.
    trig[4*16 +: 16] = 16'h4444; trig_valid = 8'h10;
    step(); trig_valid = 8'h00; step(); step();
    for (int j = 0; j < 8; j++) trig[j*16 +: 16] = 16'h2000 + 16'(j);
    trig_valid = 8'hFF;
    step(); trig_valid = 8'h00;
    for (int k = 0; k < 8; k++) begin
      step();
      exp_lane = 3'((k + 5) % 8);
      $display("rr_p5: tvalid=%0d tuser=%0d tdata=%h", m_tvalid, m_tuser, m_tdata);
      n_checks++; if (m_tvalid !== 1'b1 || m_tuser !== exp_lane || m_tdata !== (16'h2000 + 16'(exp_lane)))
        begin n_fail++; $display("FAIL rr_p5_word%0d got %0d/%0d/%h expected 1/%0d/%h", k, m_tvalid, m_tuser, m_tdata, exp_lane, 16'h2000 + 16'(exp_lane)); end
    end
    step();
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rr_p5_idle got %h expected 0", m_tvalid); end
  endtask

  task automatic test_backpressure();
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      trig[1*16 +: 16] = 16'hB100 + 16'(i); trig_valid = 8'h02;
      step();
    end
    trig_valid = 8'h00;
    n_checks++; if (overflow !== 8'h02) begin n_fail++; $display("FAIL bp_overflow got %h expected 02", overflow); end
    n_checks++; if (ovf_count !== 16'd1) begin n_fail++; $display("FAIL bp_count got %0d expected 1", ovf_count); end
    step(); step();
    n_checks++; if (m_tvalid !== 1'b1 || m_tuser !== 3'd1 || m_tdata !== 16'hB100) begin n_fail++; $display("FAIL bp_hold got %0d/%0d/%h expected 1/1/b100", m_tvalid, m_tuser, m_tdata); end
    m_tready = 1'b1;
    step();
    n_checks++; if (m_tvalid !== 1'b1 || m_tdata !== 16'hB101) begin n_fail++; $display("FAIL bp_word1 got %0d/%h expected 1/b101", m_tvalid, m_tdata); end
    step();
    n_checks++; if (m_tvalid !== 1'b1 || m_tdata !== 16'hB102) begin n_fail++; $display("FAIL bp_word2 got %0d/%h expected 1/b102", m_tvalid, m_tdata); end
    step();
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %h expected 0", m_tvalid); end
  endtask

  task automatic test_simultaneous_drops();
    m_tready = 1'b0;
    trig[5*16 +: 16] = 16'h5555; trig_valid = 8'h20; ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    trig[0 +: 16] = 16'hC000; trig[3*16 +: 16] = 16'hC003; trig[7*16 +: 16] = 16'hC007;
    trig_valid = 8'h89;
    step(); step();
    n_checks++; if (ovf_count !== 16'd0 || overflow !== 8'h00) begin n_fail++; $display("FAIL sim_pre got %0d/%h expected 0/00", ovf_count, overflow); end
    n_checks++; if (m_tvalid !== 1'b1 || m_tuser !== 3'd5) begin n_fail++; $display("FAIL sim_busy got %0d/%0d expected 1/5", m_tvalid, m_tuser); end
    step();
    trig_valid = 8'h00;
    n_checks++; if (ovf_count !== 16'd3) begin n_fail++; $display("FAIL sim_count got %0d expected 3", ovf_count); end
    n_checks++; if (overflow !== 8'h89) begin n_fail++; $display("FAIL sim_overflow got %h expected 89", overflow); end
  endtask

  task automatic test_clear_collision();
    int taken;
    trig[4*16 +: 16] = 16'hD004; trig_valid = 8'h10;
    step(); step();
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0; trig_valid = 8'h00;
    n_checks++; if (ovf_count !== 16'd1) begin n_fail++; $display("FAIL clr_count got %0d expected 1", ovf_count); end
    n_checks++; if (overflow !== 8'h10) begin n_fail++; $display("FAIL clr_overflow got %h expected 10", overflow); end
    n_checks++; if (m_tuser !== 3'd5 || m_tdata !== 16'h5555) begin n_fail++; $display("FAIL clr_hold got %0d/%h expected 5/5555", m_tuser, m_tdata); end
    // Held word plus two buffered on each of lanes 0, 3, 4, 7.
    m_tready = 1'b1; taken = 0;
    for (int i = 0; i < 12; i++) begin
      if (m_tvalid) taken++;
      step();
    end
    n_checks++; if (taken !== 9) begin n_fail++; $display("FAIL clr_drain_words got %0d expected 9", taken); end
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL clr_drain_idle got %h expected 0", m_tvalid); end
  endtask

  task automatic test_enable_mask();
    enable = 8'hFE; m_tready = 1'b0; ovf_clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      trig[0 +: 16] = 16'hE000 + 16'(i); trig_valid = 8'h01;
      step();
      ovf_clear = 1'b0;
    end
    trig_valid = 8'h00;
    step();
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL en_no_output got %h expected 0", m_tvalid); end
    n_checks++; if (overflow !== 8'h00 || ovf_count !== 16'd0) begin n_fail++; $display("FAIL en_no_overflow got %h/%0d expected 00/0", overflow, ovf_count); end
    enable = 8'hFF; m_tready = 1'b1;
  endtask

  task automatic test_saturation();
    m_tready = 1'b0;
    for (int j = 0; j < 8; j++) trig[j*16 +: 16] = 16'hF000 + 16'(j);
    trig_valid = 8'hFF;
    step(); step(); step();
    trig_valid = 8'h00; ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    n_checks++; if (ovf_count !== 16'd0) begin n_fail++; $display("FAIL sat_cleared got %0d expected 0", ovf_count); end
    trig_valid = 8'hFF;
    repeat (8191) step();
    n_checks++; if (ovf_count !== 16'hFFF8) begin n_fail++; $display("FAIL sat_bulk got %h expected fff8", ovf_count); end
    trig_valid = 8'hFE;
    step();
    n_checks++; if (ovf_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_top got %h expected ffff", ovf_count); end
    trig_valid = 8'hFF;
    step();
    trig_valid = 8'h00;
    n_checks++; if (ovf_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h expected ffff", ovf_count); end
    n_checks++; if (overflow !== 8'hFF) begin n_fail++; $display("FAIL sat_overflow got %h expected ff", overflow); end
  endtask

  task automatic test_midstream_reset();
    rst = 1'b1;
    step();
    rst = 1'b0; m_tready = 1'b1;
    n_checks++; if (m_tvalid !== 1'b0 || ovf_count !== 16'd0 || overflow !== 8'h00)
      begin n_fail++; $display("FAIL mrst_state got %0d/%h/%h expected 0/0000/00", m_tvalid, ovf_count, overflow); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL mrst_discard%0d got %h expected 0", i, m_tvalid); end
    end
    trig[0 +: 16] = 16'h0A0A; trig[1*16 +: 16] = 16'h1B1B; trig_valid = 8'h03;
    step(); trig_valid = 8'h00; step();
    n_checks++; if (m_tuser !== 3'd0 || m_tdata !== 16'h0A0A) begin n_fail++; $display("FAIL mrst_ptr_first got %0d/%h expected 0/0a0a", m_tuser, m_tdata); end
    step();
    n_checks++; if (m_tuser !== 3'd1 || m_tdata !== 16'h1B1B) begin n_fail++; $display("FAIL mrst_ptr_second got %0d/%h expected 1/1b1b", m_tuser, m_tdata); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_round_robin();
    test_backpressure();
    test_simultaneous_drops();
    test_clear_collision();
    test_enable_mask();
    test_saturation();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/turfio_trig_merge.md
# turfio_trig_merge

Trigger merger for one TURFIO port. It sits directly downstream of the per-port trigger outputs of the TURFIO interface: eight 16-bit per-SURF trigger words plus eight valid strobes. It buffers each SURF's words in a 2-entry FIFO and serializes them through a round-robin arbiter onto one valid/ready stream tagged with the SURF index. Drops are counted, never silently lost.

## Interface
Parameters:
- NUM_SURF, 8, number of SURF lanes; the index width is $clog2(NUM_SURF).
- WORD_BITS, 16, width of each trigger word.
- CNT_BITS, 16, width of the overflow counter.

Ports:
- clk_i  in  1  sysclk domain. Every input and output is synchronous to it.
- rst_i  in  1  synchronous, active-high reset.
- trig_i  in  NUM_SURF*WORD_BITS  lane j occupies bits [WORD_BITS*j +: WORD_BITS].
- trig_valid_i  in  NUM_SURF  single-cycle strobe per lane.
- enable_i  in  NUM_SURF  per-lane capture mask.
- m_tdata_o  out  WORD_BITS  merged trigger word.
- m_tuser_o  out  $clog2(NUM_SURF)  SURF index of m_tdata_o.
- m_tvalid_o  out  1  output word valid.
- m_tready_i  in  1  downstream accept.
- overflow_o  out  NUM_SURF  sticky per-lane drop flag.
- ovf_count_o  out  CNT_BITS  total dropped words; saturates.
- ovf_clear_i  in  1  clears overflow_o and ovf_count_o.

## Operation
- **Per-lane FIFO (2 entries).**
  - Push when trig_valid_i[j] && enable_i[j].
  - When enable_i[j] is low, the lane ignores new words. Words already buffered still drain.
- **Full-lane push.**
  - If the lane is also being popped this cycle, the push is accepted.
  - Otherwise the word is dropped, overflow_o[j] is set, and one is added to the drop count.
- **Drop counting.**
  - Multiple lanes dropping in the same cycle add popcount(drops) to ovf_count_o.
  - The count saturates at 2^CNT_BITS-1.
- **Output register.**
  - Loads when !m_tvalid_o || m_tready_i.
  - While m_tvalid_o && !m_tready_i, m_tdata_o and m_tuser_o are held stable.
- **Arbiter.**
  - Pointer p, reset value 0.
  - On each output-register load, grant the first non-empty lane j, searching p, p+1, … mod NUM_SURF.
  - Pop lane j, load {word, j} into the output register, then set p = (j+1) mod NUM_SURF.
  - When no lane is non-empty: m_tvalid_o drops to 0 if the current word was taken, and p is unchanged.
- **Clear.**
  - ovf_clear_i zeroes overflow_o and ovf_count_o.
  - Drops in the same cycle as a clear are applied after it: flags are set and the count equals that cycle's drop count.

## Timing
- **Reset values:** m_tvalid_o=0, m_tdata_o=0, m_tuser_o=0, overflow_o=0, ovf_count_o=0, all FIFOs empty, p=0. A reset mid-stream discards all buffered and in-flight words.
- **Latency:** a strobe in cycle N is written to the FIFO at the end of N. With the output idle, m_tvalid_o is high in cycle N+2.
- **Throughput:** one word per clock while m_tready_i=1 and any lane is non-empty.
- **Sustained load:** a lane strobing every cycle while continuously granted never overflows. It overflows when starved for ≥2 cycles with strobes arriving.
- **Pop timing:** pop and push on the same lane in the same cycle are both honoured; occupancy is unchanged.
- **Flags and counter:** overflow_o and ovf_count_o update at the end of the drop cycle and are visible the next cycle.

## Test plan
- **Single word, reset pointer:** after reset, trig_valid_i=8'h04 with lane 2 = 16'hBEEF and m_tready_i=1. Expect m_tvalid_o=1 two cycles later with m_tdata_o=16'hBEEF and m_tuser_o=2. p becomes 3, overflow_o=0.
- **Round-robin fairness:** p=0, all eight lanes strobe once simultaneously with lane j = 16'h1000+j, m_tready_i=1. Expect eight consecutive output words with m_tuser_o = 0,1,…,7 and no gaps. Repeat from p=5: expect the order 5,6,7,0,1,2,3,4.
- **Backpressure and overflow:** m_tready_i=0, lane 1 strobes 4 words on consecutive cycles. Expect the first word held in the output register, two words buffered, and the fourth dropped. Result: overflow_o=8'h02, ovf_count_o=1. After releasing ready, exactly 3 words come out, in order.
- **Simultaneous drops:** lanes 0, 3 and 7 are full, m_tready_i=0, all three strobe in one cycle. Expect ovf_count_o to increase by 3 and overflow_o=8'h89.
- **Clear collision:** assert ovf_clear_i in the same cycle as one drop on lane 4. Expect ovf_count_o=1 and overflow_o=8'h10.
- **Enable mask and saturation:**
  - enable_i=8'hFE with lane 0 strobing: expect no output and no overflow.
  - Force ovf_count_o=16'hFFFF, then cause another drop: expect the count to stay at 16'hFFFF.
